imem_load_arb: RTL and testbench
================================

# imem_load_arb

Arbiter that shares the single instruction-memory port between the pipeline fetch stage and an external program loader (UART/debug). In normal operation fetch owns the port. On a loader request the block stalls the core, drains the pipeline, grants the port to the loader for word writes, then flushes the pipeline so execution restarts on the new image. It sits between the IF stage, the loader, and a synchronous-write / combinational-read instruction memory.

## Interface
- N, 2048, memory depth in 32-bit words; word addresses at or above N are out of range.
- DRAIN_CYCLES, 4, stall cycles before the loader is granted; must be at least 1.
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_fetch_addr  in  32  PC from the IF stage.
- o_fetch_inst  out  32  instruction returned to IF.
- o_fetch_valid  out  1  high when o_fetch_inst is real memory data.
- o_core_stall  out  1  holds PC and pipeline registers.
- o_flush  out  1  one-cycle pulse that invalidates IF/ID/EX after a load session.
- i_ld_req  in  1  level request; loader holds it high for the whole session.
- o_ld_grant  out  1  loader owns the memory port.
- i_ld_valid  in  1  loader write beat is valid.
- o_ld_ready  out  1  beat is accepted this cycle.
- i_ld_addr  in  32  byte address of the beat.
- i_ld_wdata  in  32  write data.
- o_mem_addr  out  32  byte address to memory.
- o_mem_wdata  out  32  write data to memory.
- o_mem_we  out  1  memory write enable.
- i_mem_rdata  in  32  combinational read data from memory.
- o_ld_err  out  1  sticky flag: a beat was misaligned or out of range.
- o_ld_count  out  16  number of beats written in the current or last session; saturates at 16'hFFFF.

## Operation
States: RUN, DRAIN, LOAD, FLUSH.

- **RUN**
  - o_mem_addr = i_fetch_addr.
  - o_fetch_inst = i_mem_rdata; o_fetch_valid = 1.
  - o_core_stall = 0; o_ld_grant = 0.
  - If i_ld_req = 1, go to DRAIN: drain counter cleared, o_ld_err cleared.
- **DRAIN**
  - o_core_stall = 1; o_fetch_valid = 0; o_fetch_inst = 32'h0000_0013 (NOP).
  - o_mem_addr = i_fetch_addr; no writes.
  - Counter increments each cycle. When counter = DRAIN_CYCLES-1, go to LOAD and clear o_ld_count.
  - If i_ld_req drops during DRAIN, the block still completes DRAIN and LOAD, then exits LOAD on the next cycle.
- **LOAD**
  - o_core_stall = 1; o_ld_grant = 1; o_fetch_inst = NOP; o_fetch_valid = 0.
  - o_ld_ready = i_ld_req.
  - o_mem_addr = i_ld_addr; o_mem_wdata = i_ld_wdata.
  - Beat accepted when i_ld_valid & o_ld_ready.
  - Accepted beat is written (o_mem_we = 1) only if i_ld_addr[1:0] = 0 and i_ld_addr[31:2] < N, and i_reset = 0.
  - Any other accepted beat is dropped and sets o_ld_err.
  - o_ld_count increments on each written beat only.
  - If i_ld_req = 0, go to FLUSH.
- **FLUSH**
  - One cycle. o_flush = 1; o_core_stall = 1; o_fetch_valid = 0; o_ld_grant = 0.
  - Always go to RUN next.
- o_mem_we is combinational from the state and inputs. It is 0 in every state except LOAD.
- o_ld_err and o_ld_count hold their values after a session until the next DRAIN/LOAD entry.

## Timing
- Reset values:
  - State RUN.
  - o_core_stall, o_flush, o_ld_grant, o_ld_ready, o_mem_we = 0.
  - o_ld_err = 0; o_ld_count = 0; drain counter = 0.
  - o_fetch_valid = 1 after reset (RUN).
- If i_reset is high while in LOAD, o_mem_we is forced to 0 in that same cycle. RUN follows next cycle with no FLUSH pulse.
- Session timeline for i_ld_req first sampled high at edge k:
  - Cycles k+1 to k+DRAIN_CYCLES: DRAIN.
  - From k+DRAIN_CYCLES+1: LOAD.
- Write latency: zero. The beat is presented and written at the same edge.
- Throughput: one beat per cycle.
- i_ld_req falling, sampled at edge m in LOAD:
  - FLUSH for cycle m+1.
  - RUN from m+2.
  - No beat is accepted in the cycle where i_ld_req = 0.
- Fetch read is combinational in RUN: zero-cycle instruction latency.

## Test plan
- Reset then RUN: hold i_reset 2 cycles, then i_fetch_addr = 0x8 with mem word 2 = 0x00500093 -> o_fetch_inst = 0x00500093, o_fetch_valid = 1, o_core_stall = 0.
- Session entry: i_ld_req high at edge k with DRAIN_CYCLES = 4 -> o_core_stall = 1 from k+1, o_ld_grant = 1 exactly at k+5, o_fetch_inst = 0x00000013 throughout.
- Back-to-back load: 3 beats at addresses 0x0, 0x4, 0x8 with data 0xA, 0xB, 0xC on consecutive cycles -> three o_mem_we pulses, o_ld_count = 3, o_ld_err = 0; after exit, fetch at 0x4 returns 0xB.
- Bad beats with N = 2048: addresses 0x2 (misaligned) and 0x2000 (word 2048) -> o_mem_we = 0 for both, o_ld_err = 1, o_ld_count unchanged; o_ld_err clears on the next session's DRAIN entry.
- Exit: drop i_ld_req at edge m with i_ld_valid = 1 -> no write at m, o_flush = 1 for one cycle, o_core_stall = 0 and o_fetch_valid = 1 from m+2.
- Reset mid-LOAD: assert i_reset during a valid in-range beat -> o_mem_we = 0 that cycle, RUN next cycle, o_flush never asserted, o_ld_count = 0.

Source files
------------

// File: rtl/imem_load_arb.sv
// Shares the instruction-memory port between the IF stage and an external program loader.
// Loader sessions stall the core, drain the pipeline, write the image, then flush and resume.
module imem_load_arb #(
  parameter int N            = 2048,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetch_addr,
  output logic [31:0] o_fetch_inst,
  output logic        o_fetch_valid,
  output logic        o_core_stall,
  output logic        o_flush,
  input  logic        i_ld_req,
  output logic        o_ld_grant,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_wdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rdata,
  output logic        o_ld_err,
  output logic [15:0] o_ld_count
);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD, FLUSH} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] drain_cnt;
  logic          beat_accept;
  logic          beat_ok;

  // A beat is writable only if word-aligned and inside the memory.
  assign beat_ok     = (i_ld_addr[1:0] == 2'b00) && ({2'b00, i_ld_addr[31:2]} < 32'(N));
  assign beat_accept = (state == LOAD) && i_ld_valid && i_ld_req;

  // NOTE: every output and the next state get a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    o_mem_addr    = i_fetch_addr;
    o_mem_wdata   = i_ld_wdata;
    o_mem_we      = 1'b0;
    o_fetch_inst  = NOP;
    o_fetch_valid = 1'b0;
    o_core_stall  = 1'b1;
    o_flush       = 1'b0;
    o_ld_grant    = 1'b0;
    o_ld_ready    = 1'b0;
    case (state)
      RUN: begin
        o_fetch_inst  = i_mem_rdata;
        o_fetch_valid = 1'b1;
        o_core_stall  = 1'b0;
        if (i_ld_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = LOAD;
      end
      LOAD: begin
        o_ld_grant = 1'b1;
        o_ld_ready = i_ld_req;
        o_mem_addr = i_ld_addr;
        o_mem_we   = beat_accept && beat_ok && !i_reset;
        if (!i_ld_req) state_nxt = FLUSH;
      end
      FLUSH: begin
        o_flush   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= RUN;
      drain_cnt  <= '0;
      o_ld_err   <= 1'b0;
      o_ld_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        RUN: begin
          if (i_ld_req) begin
            drain_cnt <= '0;
            o_ld_err  <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt  <= '0;
            o_ld_count <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (o_mem_we && (o_ld_count != 16'hFFFF)) o_ld_count <= o_ld_count + 16'd1;
          if (beat_accept && !beat_ok) o_ld_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arb.sv
// Self-checking bench for imem_load_arb: a local memory model plus a write scoreboard
// that expects each legal loader beat to appear on the memory port in order.
module tb_imem_load_arb;

  localparam int N  = 2048;
  localparam int DC = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic        ld_req = 1'b0, ld_valid = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic [31:0] fetch_inst, mem_addr, mem_wdata, mem_rdata;
  logic        fetch_valid, core_stall, flush, ld_grant, ld_ready, mem_we, ld_err;
  logic [15:0] ld_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];

  logic [31:0] mem [0:N-1];

  imem_load_arb #(.N(N), .DRAIN_CYCLES(DC)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_fetch_addr(fetch_addr), .o_fetch_inst(fetch_inst), .o_fetch_valid(fetch_valid),
    .o_core_stall(core_stall), .o_flush(flush),
    .i_ld_req(ld_req), .o_ld_grant(ld_grant), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .i_mem_rdata(mem_rdata),
    .o_ld_err(ld_err), .o_ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // Synchronous-write, combinational-read instruction memory.
  assign mem_rdata = (mem_addr[31:13] == '0) ? mem[mem_addr[12:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && mem_addr[31:13] == '0) mem[mem_addr[12:2]] = mem_wdata;
  end

  // Every memory write must match the oldest expected beat.
  always @(negedge clk) begin : scoreboard
    beat_t b;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        b = exp_q.pop_front();
        if (mem_addr !== b.addr || mem_wdata !== b.data) begin
          errors++;
          $display("FAIL write_beat: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_wdata, b.addr, b.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    int n = 0;
    step();
    ld_req = 1'b1;
    do begin
      step();
      @(negedge clk);
      n++;
    end while (!ld_grant && n < 20);
    checks++;
    if (ld_grant !== 1'b1) begin
      errors++;
      $display("FAIL grant_timeout: grant=%b after %0d cycles, expected 1", ld_grant, n);
    end
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] d, input bit good);
    step();
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_wdata = d;
    if (good) exp_q.push_back('{addr: a, data: d});
    @(negedge clk);
    checks++;
    if (mem_we !== good) begin
      errors++;
      $display("FAIL beat_we addr=%h: got we=%b, expected %b", a, mem_we, good);
    end
  endtask

  task automatic end_session();
    step();
    ld_req   = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b we=%b flush=%b, expected 0 0 0", ld_ready, mem_we, flush);
    end
    step();
    reset = 1'b0;
    fetch_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (fetch_inst !== 32'h0050_0093 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_fetch: got inst=%h valid=%b, expected 00500093 1", fetch_inst, fetch_valid);
    end
    checks++;
    if (core_stall !== 1'b0 || ld_grant !== 1'b0 || ld_err !== 1'b0 || ld_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b grant=%b err=%b count=%0d, expected 0 0 0 0",
               core_stall, ld_grant, ld_err, ld_count);
    end
  endtask

  task automatic test_session_entry();
    step();
    ld_req = 1'b1;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b0) begin
      errors++;
      $display("FAIL entry_pre_stall: got %b, expected 0", core_stall);
    end
    for (int i = 1; i <= DC + 1; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (core_stall !== 1'b1 || fetch_inst !== NOP || fetch_valid !== 1'b0) begin
        errors++;
        $display("FAIL entry_stall cycle %0d: got stall=%b inst=%h valid=%b, expected 1 00000013 0",
                 i, core_stall, fetch_inst, fetch_valid);
      end
      checks++;
      if (ld_grant !== (i == DC + 1)) begin
        errors++;
        $display("FAIL entry_grant cycle %0d: got %b, expected %b", i, ld_grant, (i == DC + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive_beat(32'(i * 4), 32'hA + 32'(i), 1'b1);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_count !== 16'd3 || ld_err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got count=%0d err=%b pending=%0d, expected 3 0 0", ld_count, ld_err, exp_q.size());
    end
    end_session();
    step();
    fetch_addr = 32'h4;
    @(negedge clk);
    checks++;
    if (fetch_inst !== 32'hB || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_fetch: got inst=%h valid=%b, expected 0000000b 1", fetch_inst, fetch_valid);
    end
  endtask

  task automatic test_bad_beats();
    start_session();
    drive_beat(32'h10, 32'hD, 1'b1);
    drive_beat(32'h2, 32'hBAD0, 1'b0);
    drive_beat(32'h2000, 32'hBAD1, 1'b0);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_err !== 1'b1 || ld_count !== 16'd1) begin
      errors++;
      $display("FAIL bad_flags: got err=%b count=%0d, expected 1 1", ld_err, ld_count);
    end
    end_session();
    checks++;
    if (ld_err !== 1'b1 || ld_count !== 16'd1 || core_stall !== 1'b0) begin
      errors++;
      $display("FAIL bad_hold: got err=%b count=%0d stall=%b, expected 1 1 0", ld_err, ld_count, core_stall);
    end
    step();
    ld_req = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (ld_err !== 1'b0 || ld_count !== 16'd1 || core_stall !== 1'b1) begin
      errors++;
      $display("FAIL bad_drain_clear: got err=%b count=%0d stall=%b, expected 0 1 1", ld_err, ld_count, core_stall);
    end
    begin : wait_grant
      int n = 0;
      while (!ld_grant && n < 20) begin
        step();
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (ld_grant !== 1'b1 || ld_count !== 16'd0) begin
      errors++;
      $display("FAIL bad_load_entry: got grant=%b count=%0d, expected 1 0", ld_grant, ld_count);
    end
  endtask

  task automatic test_exit();
    step();
    ld_req   = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h20;
    ld_wdata = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL exit_no_write: got we=%b ready=%b, expected 0 0", mem_we, ld_ready);
    end
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || core_stall !== 1'b1 || ld_grant !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL exit_flush: got flush=%b stall=%b grant=%b valid=%b, expected 1 1 0 0",
               flush, core_stall, ld_grant, fetch_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (flush !== 1'b0 || core_stall !== 1'b0 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL exit_run: got flush=%b stall=%b valid=%b, expected 0 0 1", flush, core_stall, fetch_valid);
    end
    checks++;
    if (mem[8] !== 32'h0) begin
      errors++;
      $display("FAIL exit_mem: got mem[8]=%h, expected 00000000", mem[8]);
    end
  endtask

  task automatic test_reset_mid_load();
    start_session();
    drive_beat(32'h40, 32'h77, 1'b1);
    step();
    ld_valid = 1'b1;
    ld_addr  = 32'h30;
    ld_wdata = 32'h55;
    reset    = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_we: got %b, expected 0", mem_we);
    end
    step();
    reset    = 1'b0;
    ld_req   = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b0 || fetch_valid !== 1'b1 || flush !== 1'b0 || ld_count !== 16'd0 || ld_grant !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_run: got stall=%b valid=%b flush=%b count=%0d grant=%b, expected 0 1 0 0 0",
               core_stall, fetch_valid, flush, ld_count, ld_grant);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (flush !== 1'b0) begin
        errors++;
        $display("FAIL rst_load_flush cycle %0d: got %b, expected 0", i, flush);
      end
    end
    checks++;
    if (exp_q.size() != 0 || mem[12] !== 32'h0) begin
      errors++;
      $display("FAIL rst_load_mem: got pending=%0d mem[12]=%h, expected 0 00000000", exp_q.size(), mem[12]);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 32'h0;
    mem[2] = 32'h0050_0093;
    test_reset();
    test_session_entry();
    test_back_to_back();
    test_bad_beats();
    test_exit();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
